// File: rtl/nx_fifo_rd_skid.sv
// Read-side skid stage: turns an nx_fifo empty/ren/rdata pop port into a registered valid/ready stream.
// Optional stall statistics counter is built when NX_FIFO_RD_SKID_STALL_CNT_EN is defined.
module nx_fifo_rd_skid #(
    parameter int unsigned WIDTH      = 611,
    parameter bit          DATA_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_ren,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [15:0]      stall_cnt
);

    typedef enum logic [1:0] {
        CNT_0 = 2'd0,
        CNT_1 = 2'd1,
        CNT_2 = 2'd2
    } cnt_e;

    cnt_e             cnt_q, cnt_d;
    logic [WIDTH-1:0] ent0_q, ent1_q;
    logic [WIDTH-1:0] ent0_d, ent1_d;
    logic             push, pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= CNT_0;
        else        cnt_q <= cnt_d;
    end

    // fifo_ren never looks at out_ready: a free slot is guaranteed whenever count != 2.
    always_comb begin
        fifo_ren  = !fifo_empty && (cnt_q != CNT_2) && !clear;
        out_valid = (cnt_q != CNT_0);
        out_data  = out_valid ? ent0_q : '0;
        occupancy = cnt_q;
        push      = fifo_ren;
        pop       = out_valid && out_ready;
    end

    always_comb begin
        cnt_d  = cnt_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        if (clear) begin
            cnt_d = CNT_0;
        end else begin
            case (cnt_q)
                CNT_0: begin
                    if (push) begin
                        ent0_d = fifo_rdata;
                        cnt_d  = CNT_1;
                    end
                end
                CNT_1: begin
                    if (push && pop) begin
                        ent0_d = fifo_rdata;
                    end else if (push) begin
                        ent1_d = fifo_rdata;
                        cnt_d  = CNT_2;
                    end else if (pop) begin
                        cnt_d = CNT_0;
                    end
                end
                CNT_2: begin
                    if (pop) begin
                        ent0_d = ent1_q;
                        cnt_d  = CNT_1;
                    end
                end
                default: cnt_d = CNT_0;
            endcase
        end
    end

    generate
        if (DATA_RESET) begin : g_data_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ent0_q <= '0;
                    ent1_q <= '0;
                end else begin
                    ent0_q <= ent0_d;
                    ent1_q <= ent1_d;
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk) begin
                ent0_q <= ent0_d;
                ent1_q <= ent1_d;
            end
        end
    endgenerate

`ifdef NX_FIFO_RD_SKID_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_nx_fifo_rd_skid.sv
// Directed bench for nx_fifo_rd_skid: per-cycle vector table plus reset and stall-counter sequences.
module tb_nx_fifo_rd_skid;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          fifo_empty;
    logic [W-1:0]  fifo_rdata;
    logic          fifo_ren;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    nx_fifo_rd_skid #(
        .WIDTH      (W),
        .DATA_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         empty;
        logic [W-1:0] rdata;
        logic         ready;
        logic         clr;
        logic         ren;
        logic         valid;
        logic [W-1:0] data;
        logic [1:0]   occ;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    function automatic vec_t mk(logic e, logic [W-1:0] rd, logic rdy, logic c,
                                logic ren, logic v, logic [W-1:0] d, logic [1:0] o);
        vec_t t;
        t.empty = e; t.rdata = rd; t.ready = rdy; t.clr = c;
        t.ren = ren; t.valid = v; t.data = d; t.occ = o;
        return t;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Stream 3 words with out_ready high
        vecs[0]  = mk(1, 32'h00, 1, 0,  0, 0, 32'h00, 0);
        vecs[1]  = mk(0, 32'h01, 1, 0,  1, 0, 32'h00, 0);
        vecs[2]  = mk(0, 32'h02, 1, 0,  1, 1, 32'h01, 1);
        vecs[3]  = mk(0, 32'h03, 1, 0,  1, 1, 32'h02, 1);
        vecs[4]  = mk(1, 32'h00, 1, 0,  0, 1, 32'h03, 1);
        vecs[5]  = mk(1, 32'h00, 1, 0,  0, 0, 32'h00, 0);
        // 5 words under backpressure, then drain
        vecs[6]  = mk(0, 32'h11, 0, 0,  1, 0, 32'h00, 0);
        vecs[7]  = mk(0, 32'h12, 0, 0,  1, 1, 32'h11, 1);
        vecs[8]  = mk(0, 32'h13, 0, 0,  0, 1, 32'h11, 2);
        vecs[9]  = mk(0, 32'h13, 0, 0,  0, 1, 32'h11, 2);
        vecs[10] = mk(0, 32'h13, 1, 0,  0, 1, 32'h11, 2);
        vecs[11] = mk(0, 32'h13, 1, 0,  1, 1, 32'h12, 1);
        vecs[12] = mk(0, 32'h14, 1, 0,  1, 1, 32'h13, 1);
        vecs[13] = mk(0, 32'h15, 1, 0,  1, 1, 32'h14, 1);
        vecs[14] = mk(1, 32'h00, 1, 0,  0, 1, 32'h15, 1);
        vecs[15] = mk(1, 32'h00, 1, 0,  0, 0, 32'h00, 0);
        // Toggling out_ready at occupancy 2
        vecs[16] = mk(0, 32'h21, 0, 0,  1, 0, 32'h00, 0);
        vecs[17] = mk(0, 32'h22, 0, 0,  1, 1, 32'h21, 1);
        vecs[18] = mk(0, 32'h23, 1, 0,  0, 1, 32'h21, 2);
        vecs[19] = mk(0, 32'h23, 0, 0,  1, 1, 32'h22, 1);
        vecs[20] = mk(0, 32'h24, 1, 0,  0, 1, 32'h22, 2);
        vecs[21] = mk(0, 32'h24, 0, 0,  1, 1, 32'h23, 1);
        vecs[22] = mk(0, 32'h25, 0, 0,  0, 1, 32'h23, 2);
        // clear at occupancy 2 with FIFO non-empty, then refill
        vecs[23] = mk(0, 32'h25, 0, 1,  0, 1, 32'h23, 2);
        vecs[24] = mk(0, 32'h25, 0, 0,  1, 0, 32'h00, 0);
        vecs[25] = mk(1, 32'h00, 1, 0,  0, 1, 32'h25, 1);
        vecs[26] = mk(1, 32'h00, 1, 0,  0, 0, 32'h00, 0);
        // clear coinciding with a pop handshake
        vecs[27] = mk(0, 32'h31, 1, 0,  1, 0, 32'h00, 0);
        vecs[28] = mk(0, 32'h32, 1, 1,  0, 1, 32'h31, 1);
        vecs[29] = mk(1, 32'h00, 1, 0,  0, 0, 32'h00, 0);

        rst_n = 1'b0; clear = 1'b0; fifo_empty = 1'b1; fifo_rdata = '0; out_ready = 1'b0;
        #12;
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_ren",   {31'b0, fifo_ren},  32'h0);
        chk("rst_occ",   {30'b0, occupancy}, 32'h0);
        chk("rst_data",  out_data,           32'h0);
        chk("rst_stall", {16'b0, stall_cnt}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            fifo_empty = vecs[i].empty;
            fifo_rdata = vecs[i].rdata;
            out_ready  = vecs[i].ready;
            clear      = vecs[i].clr;
            #1;
            chk($sformatf("v%0d_ren", i),   {31'b0, fifo_ren},  {31'b0, vecs[i].ren});
            chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].valid});
            chk($sformatf("v%0d_data", i),  out_data,           vecs[i].data);
            chk($sformatf("v%0d_occ", i),   {30'b0, occupancy}, {30'b0, vecs[i].occ});
        end

        // Asynchronous reset mid-stream, between clock edges
        @(negedge clk); fifo_empty = 1'b0; fifo_rdata = 32'h41; out_ready = 1'b0; clear = 1'b0;
        @(negedge clk); fifo_rdata = 32'h42;
        @(negedge clk); fifo_rdata = 32'h43;
        #1;
        chk("pre_arst_occ", {30'b0, occupancy}, 32'h2);
        #2;
        rst_n = 1'b0; fifo_empty = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_ren",   {31'b0, fifo_ren},  32'h0);
        chk("arst_occ",   {30'b0, occupancy}, 32'h0);
        chk("arst_data",  out_data,           32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Hold one word under backpressure to exercise the stall counter
        @(negedge clk); fifo_empty = 1'b0; fifo_rdata = 32'h51; out_ready = 1'b0;
        @(negedge clk); fifo_empty = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
`ifdef NX_FIFO_RD_SKID_STALL_CNT_EN
        chk("stall_10", {16'b0, stall_cnt}, 32'd10);
        repeat (70000) @(posedge clk);
        @(negedge clk); #1;
        chk("stall_sat", {16'b0, stall_cnt}, 32'hFFFF);
`else
        chk("stall_10", {16'b0, stall_cnt}, 32'd0);
        repeat (200) @(posedge clk);
        @(negedge clk); #1;
        chk("stall_sat", {16'b0, stall_cnt}, 32'h0);
`endif
        chk("stall_hold_data", out_data, 32'h51);
        chk("stall_hold_occ",  {30'b0, occupancy}, 32'h1);
        clear = 1'b1;
        @(negedge clk); clear = 1'b0; #1;
        chk("clr_occ", {30'b0, occupancy}, 32'h0);
`ifdef NX_FIFO_RD_SKID_STALL_CNT_EN
        chk("clr_stall", {16'b0, stall_cnt}, 32'hFFFF);
`else
        chk("clr_stall", {16'b0, stall_cnt}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
